// File: rtl/mm_pkg.sv
// Shared types for the serial run-detector datapath: the serializer FSM
// state and the default word width used by the feeder stage.
package mm_pkg;

  typedef enum logic [0:0] {
    SER_IDLE,
    SER_SHIFT
  } ser_state_t;

  localparam int MM_WORD_W = 8;

endpackage

// File: rtl/mm_bit_serializer.sv
// Parallel-to-serial feeder: accepts words on a valid/ready handshake and
// emits one bit per unpaused cycle, with dout_cen qualifying each bit.
module mm_bit_serializer
  import mm_pkg::*;
#(
  parameter int WIDTH     = MM_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             pause,
  output logic             dout_bit,
  output logic             dout_cen,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_shifted;
  logic             head_bit;
  logic             accept;

  // Shift toward whichever end is currently presented on dout_bit.
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_q[WIDTH-1:1]};
  assign head_bit     = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

  assign busy     = (state_q == SER_SHIFT);
  assign dout_bit = busy & head_bit;
  assign dout_cen = busy & ~pause;
  assign last_bit = dout_cen & (cnt_q == CNT_LAST);
  // in_ready depends combinationally on pause through last_bit.
  assign in_ready = (state_q == SER_IDLE) | last_bit;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (dout_cen) begin
      if (cnt_q == CNT_LAST) begin
        state_d = SER_IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end else begin
        sreg_d = sreg_shifted;
        cnt_d  = cnt_q + CW'(1);
      end
    end
    // A reload on the final bit overrides the drain, keeping the stream gapless.
    if (accept) begin
      state_d = SER_SHIFT;
      sreg_d  = in_data;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= SER_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mm_bit_serializer.sv
// Directed bench for mm_bit_serializer: an MSB-first and an LSB-first
// instance share stimulus; expected bit streams are hand-written constants.
module tb_mm_bit_serializer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       pause;
  logic [7:0] in_data;

  logic m_ready, m_bit, m_cen, m_last, m_busy;
  logic l_ready, l_bit, l_cen, l_last, l_busy;

  int tests = 0;
  int fails = 0;

  logic [7:0]  seq8;
  logic [15:0] seq16;
  logic [10:0] seq11;

  always #5 clk = ~clk;

  mm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(m_ready),
    .in_data(in_data), .pause(pause), .dout_bit(m_bit), .dout_cen(m_cen),
    .last_bit(m_last), .busy(m_busy)
  );

  mm_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(l_ready),
    .in_data(in_data), .pause(pause), .dout_bit(l_bit), .dout_cen(l_cen),
    .last_bit(l_last), .busy(l_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic p);
    in_valid = v;
    in_data  = d;
    pause    = p;
  endtask

  task automatic check1(input string tag, input string name, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s %s: got %b expected %b", tag, name, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input bit use_lsb, input logic e_bit,
                             input logic e_cen, input logic e_last, input logic e_ready,
                             input logic e_busy);
    #1;
    check1(tag, "dout_bit", use_lsb ? l_bit   : m_bit,   e_bit);
    check1(tag, "dout_cen", use_lsb ? l_cen   : m_cen,   e_cen);
    check1(tag, "last_bit", use_lsb ? l_last  : m_last,  e_last);
    check1(tag, "in_ready", use_lsb ? l_ready : m_ready, e_ready);
    check1(tag, "busy",     use_lsb ? l_busy  : m_busy,  e_busy);
  endtask

  initial begin
    resetn = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick(); tick();
    checkOutput("reset_held", 0, 0, 0, 0, 1, 0);
    resetn = 1'b1;
    tick();
    checkOutput("reset_released", 0, 0, 0, 0, 1, 0);

    // Single word B4, MSB first; in_data churns while busy and must be ignored.
    applyStimulus(1'b1, 8'hB4, 1'b0);
    checkOutput("t1_accept", 0, 0, 0, 0, 1, 0);
    tick();
    seq8 = 8'b10110100;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, (i % 2 == 0) ? 8'h5A : 8'hC3, 1'b0);
      checkOutput($sformatf("t1_b%0d", i), 0, seq8[7-i], 1, i == 7, i == 7, 1);
      tick();
    end
    checkOutput("t1_idle", 0, 0, 0, 0, 1, 0);

    // Back-to-back F0 then 0F, reloaded on the first word's last bit.
    applyStimulus(1'b1, 8'hF0, 1'b0);
    checkOutput("t2_accept", 0, 0, 0, 0, 1, 0);
    tick();
    seq16 = 16'b1111000000001111;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i < 8, 8'h0F, 1'b0);
      checkOutput($sformatf("t2_b%0d", i), 0, seq16[15-i], 1,
                  (i == 7) || (i == 15), (i == 7) || (i == 15), 1);
      tick();
    end
    checkOutput("t2_idle", 0, 0, 0, 0, 1, 0);

    // A5 with pause over cycles N+3..N+5: the third bit is held, then counted.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("t3_accept", 0, 0, 0, 0, 1, 0);
    tick();
    seq11 = 11'b10111100101;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 8'hFF, (i >= 2) && (i <= 4));
      checkOutput($sformatf("t3_c%0d", i), 0, seq11[10-i], !((i >= 2) && (i <= 4)),
                  i == 10, i == 10, 1);
      tick();
    end
    checkOutput("t3_idle", 0, 0, 0, 0, 1, 0);

    // Accept with pause high in IDLE, then pause on the last bit with a word waiting.
    applyStimulus(1'b1, 8'h81, 1'b1);
    checkOutput("t3b_accept_paused_idle", 0, 0, 0, 0, 1, 0);
    tick();
    seq8 = 8'b10000001;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("t3b_b%0d", i), 0, seq8[7-i], 1, 0, 0, 1);
      tick();
    end
    applyStimulus(1'b1, 8'h3C, 1'b1);
    checkOutput("t3b_last_paused", 0, 1, 0, 0, 0, 1);
    tick();
    applyStimulus(1'b1, 8'h3C, 1'b0);
    checkOutput("t3b_last_resume", 0, 1, 1, 1, 1, 1);
    tick();
    seq8 = 8'b00111100;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("t3b_w2_b%0d", i), 0, seq8[7-i], 1, i == 7, i == 7, 1);
      tick();
    end
    checkOutput("t3b_idle", 0, 0, 0, 0, 1, 0);

    // Reset asserted during the fourth bit of FF discards the word.
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("t4_accept", 0, 0, 0, 0, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("t4_b%0d", i), 0, 1, 1, 0, 0, 1);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    resetn = 1'b0;
    checkOutput("t4_b3_in_reset", 0, 1, 1, 0, 0, 1);
    tick();
    checkOutput("t4_after_reset", 0, 0, 0, 0, 1, 0);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("t4_reset_and_valid", 0, 0, 0, 0, 1, 0);
    tick();
    resetn = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t4_word_dropped", 0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("t4_still_idle", 0, 0, 0, 0, 1, 0);

    // LSB-first instance on B4.
    applyStimulus(1'b1, 8'hB4, 1'b0);
    checkOutput("t5_accept", 1, 0, 0, 0, 1, 0);
    tick();
    seq8 = 8'b00101101;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("t5_b%0d", i), 1, seq8[7-i], 1, i == 7, i == 7, 1);
      tick();
    end
    checkOutput("t5_idle", 1, 0, 0, 0, 1, 0);

    // in_valid toggles with random data while busy; only 69 may be emitted.
    applyStimulus(1'b1, 8'h69, 1'b0);
    checkOutput("t6_accept", 0, 0, 0, 0, 1, 0);
    tick();
    seq8 = 8'b01101001;
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i < 7) && (i % 2 == 0), 8'($urandom_range(0, 255)), 1'b0);
      checkOutput($sformatf("t6_b%0d", i), 0, seq8[7-i], 1, i == 7, i == 7, 1);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6_idle", 0, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
